// File: rtl/capture_pkg.sv
// Shared definitions for the capture stream buffer.
// - Default parameter values used by the top and the bench.
// - arb_t and rr_next(): the round-robin winner search, which any channel count up to MAX_CH can
//   use. The per-instance entry struct depends on the instance parameters, so it is declared
//   inside the top.
package capture_pkg;

    localparam int unsigned MAX_CH        = 16;
    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 8;
    localparam int unsigned DEFAULT_TS_W  = 16;
    localparam int unsigned DEFAULT_CNT_W = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } arb_t;

    // Scan channels rr+1, rr+2, ... (mod num_ch). The first requesting channel wins.
    function automatic arb_t rr_next(input logic [MAX_CH-1:0] req,
                                     input logic [3:0]        rr,
                                     input int unsigned       num_ch);
        arb_t        res;
        int unsigned c;
        logic [3:0]  c4;
        res = '0;
        for (int unsigned k = 1; k <= MAX_CH; k++) begin
            if (k <= num_ch && !res.found) begin
                c  = (32'(rr) + k) % num_ch;
                c4 = 4'(c);
                if (req[c4]) begin
                    res.found = 1'b1;
                    res.idx   = c4;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO of packed capture entries.
// The occupancy counter decides full and empty. The head is read from registered storage at the
// registered read pointer, so an entry written into an empty FIFO shows on the outputs one cycle
// later. It stays stable until it is popped.
// Ports:
//   clk, reset           clock, async active-low reset (storage cleared)
//   push, push_data      write request and entry; ignored when full
//   out_ready            downstream accept; pops when out_valid is high
//   out_valid, out_entry head valid and head entry
//   level                current occupancy, 0..DEPTH
module capture_fifo #(
    parameter int unsigned EW    = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [EW-1:0]            push_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [EW-1:0]            out_entry,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] count_q, count_d;
    logic             full, empty, do_push, do_pop;

    assign full    = (count_q == LVL_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = out_ready && !empty;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers are power-of-two wide and wrap on overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign out_valid = !empty;
    assign out_entry = mem_q[rd_ptr_q];
    assign level     = count_q;

endmodule

// File: rtl/capture_stream_buf.sv
// Multi-channel capture buffer.
// It arbitrates NUM_CH valid/ready inputs round-robin and stamps each accepted word with its
// channel id and a free-running timestamp. The stamped words are queued in a DEPTH-entry FIFO
// and drained on one valid/ready output stream.
// Ports:
//   clk, reset             clock, async active-low reset
//   en                     capture enable; low blocks all accepts
//   in_valid/in_data       per-channel inputs; channel i at in_data[i*WIDTH +: WIDTH]
//   in_ready               one-hot (or zero) accept to the winning channel
//   out_valid/out_ready    output handshake
//   out_data/out_ch/out_ts head entry fields
//   level                  FIFO occupancy
//   stall_cnt              saturating count of cycles blocked by a full FIFO
module capture_stream_buf
    import capture_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned TS_W   = DEFAULT_TS_W,
    parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [NUM_CH-1:0]         in_valid,
    input  logic [NUM_CH*WIDTH-1:0]   in_data,
    output logic [NUM_CH-1:0]         in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic [TS_W-1:0]           out_ts,
    output logic [$clog2(DEPTH):0]    level,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CH_W-1:0]  ch;
        logic [TS_W-1:0]  ts;
    } entry_t;

    localparam int unsigned EW = $bits(entry_t);

    logic [TS_W-1:0]  ts_q;
    logic [CH_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    arb_t             arb;
    logic [CH_W-1:0]  win_idx;
    logic [WIDTH-1:0] win_data;
    logic             full, accept, stall;
    entry_t           push_entry, head;
    logic [EW-1:0]    head_bits;

    assign full = (level == LVL_W'(DEPTH));

    always_comb begin
        arb     = rr_next(MAX_CH'(in_valid), 4'(rr_q), NUM_CH);
        win_idx = CH_W'(arb.idx);
    end

    // reset gates the accept path too, so in_ready reads 0 while reset is held
    assign accept = arb.found && en && !full && reset;
    // A pop in the same cycle does not free a slot for the winner.
    assign stall  = en && (|in_valid) && full;

    always_comb begin
        in_ready = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (win_idx == CH_W'(i)) begin
                in_ready[i] = accept;
                win_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        rr_d    = accept ? win_idx : rr_q;
        stall_d = stall_q;
        if (stall && !(&stall_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        push_entry = '{data: win_data, ch: win_idx, ts: ts_q};
    end

    // rr starts at the last channel so that channel 0 is searched first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q    <= '0;
            rr_q    <= CH_W'(NUM_CH - 1);
            stall_q <= '0;
        end else begin
            ts_q    <= ts_q + TS_W'(1);
            rr_q    <= rr_d;
            stall_q <= stall_d;
        end
    end

    capture_fifo #(
        .EW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (push_entry),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_entry (head_bits),
        .level     (level)
    );

    assign head      = entry_t'(head_bits);
    assign out_data  = head.data;
    assign out_ch    = head.ch;
    assign out_ts    = head.ts;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_capture_stream_buf.sv
// Bench for capture_stream_buf.
// The DUT is built with a 4-bit timestamp and a 4-bit stall counter, so timestamp wrap and
// counter saturation can be reached in a short run.
// The reference model works at transaction level: a queue of {data, ch, ts}, the last granted
// channel, a cycle count for the timestamp, and a saturating stall count.
module tb_capture_stream_buf;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int TS_W   = 4;
    localparam int CNT_W  = 4;

    logic        clk, reset, en, out_ready;
    logic [3:0]  in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic [3:0]  out_ts;
    logic [3:0]  level;
    logic [3:0]  stall_cnt;

    capture_stream_buf #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .TS_W   (TS_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ts    (out_ts),
        .level     (level),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         ch;
        int         ts;
    } ent_t;

    ent_t q[$];
    int   m_ts, m_rr, m_stall;
    int   checks, errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input logic [3:0] v);
        for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (m_rr + k) % NUM_CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle, advance the model across the edge.
    task automatic step(input logic e, input logic [3:0] v, input logic [31:0] d,
                        input logic r, output logic [3:0] got);
        int         w;
        logic [3:0] er;
        bit         was_full;
        en = e; in_valid = v; in_data = d; out_ready = r;
        @(negedge clk);
        w        = winner(v);
        was_full = (q.size() == DEPTH);
        er       = '0;
        if (e && !was_full && w >= 0) er[w] = 1'b1;
        got = in_ready;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("level", 32'(level), q.size());
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("stall_cnt", 32'(stall_cnt), m_stall);
        if (q.size() > 0) begin
            chk("out_data", 32'(out_data), 32'(q[0].d));
            chk("out_ch", 32'(out_ch), q[0].ch);
            chk("out_ts", 32'(out_ts), q[0].ts);
        end
        if (r && q.size() > 0) void'(q.pop_front());
        if (er != 0) begin
            q.push_back('{d[w*8 +: 8], w, m_ts});
            m_rr = w;
        end
        if (e && v != 0 && was_full && m_stall < (1 << CNT_W) - 1) m_stall++;
        m_ts = (m_ts + 1) % (1 << TS_W);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; en = 1'b1; in_valid = 4'hF; in_data = $urandom; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_out_ts", 32'(out_ts), 0);
        q.delete();
        m_ts = 0; m_rr = NUM_CH - 1; m_stall = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] g;
        checks = 0; errors = 0;
        reset = 1'b1; en = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // First capture: ch0 sends A5 when ts is 3.
        for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 32'h0, 1'b0, g);
        step(1'b1, 4'b0001, 32'h0000_00A5, 1'b0, g);
        chk("first_data", 32'(out_data), 32'hA5);
        chk("first_ch", 32'(out_ch), 0);
        chk("first_ts", 32'(out_ts), 3);
        chk("first_valid", 32'(out_valid), 1);

        // All channels valid with a free-flowing output: grants rotate from ch0.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(1'b1, 4'hF, $urandom, 1'b1, g);
            chk("rr_order", 32'(g), 32'(1 << (k % NUM_CH)));
        end

        // Fill from ch1 with the output blocked, then hold the ninth word.
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 32'h0, 1'b1, g);
        for (int i = 0; i < 8; i++) step(1'b1, 4'b0010, {16'h0, 8'(8'h10 + i), 8'h0}, 1'b0, g);
        chk("fill_level", 32'(level), 8);
        for (int i = 0; i < 20; i++) step(1'b1, 4'b0010, 32'h0000_1900, 1'b0, g);
        chk("stall_sat", 32'(stall_cnt), 15);
        // Full with a pop: no accept this cycle, accept on the next.
        step(1'b1, 4'b0010, 32'h0000_1900, 1'b1, g);
        chk("full_pop_ready", 32'(g), 0);
        chk("full_pop_level", 32'(level), 7);
        step(1'b1, 4'b0010, 32'h0000_1900, 1'b0, g);
        chk("refill_ready", 32'(g), 32'b0010);
        chk("refill_level", 32'(level), 8);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", 32'(out_data), (i < 7) ? 32'(8'h11 + i) : 32'h19);
            step(1'b0, 4'h0, 32'h0, 1'b1, g);
        end
        chk("drained_level", 32'(level), 0);

        // Timestamp wrap: captures at ts 15 and ts 0.
        for (int i = 0; i < 20 && m_ts != 15; i++) step(1'b1, 4'h0, 32'h0, 1'b1, g);
        step(1'b1, 4'b0001, 32'h0000_00C1, 1'b1, g);
        chk("ts_wrap_15", 32'(out_ts), 15);
        step(1'b1, 4'b0001, 32'h0000_00C2, 1'b1, g);
        chk("ts_wrap_0", 32'(out_ts), 0);
        step(1'b1, 4'h0, 32'h0, 1'b1, g);

        // Reset while five entries are buffered.
        for (int i = 0; i < 5; i++) step(1'b1, 4'b0100, $urandom, 1'b0, g);
        chk("pre_reset_level", 32'(level), 5);
        do_reset();
        step(1'b1, 4'hF, $urandom, 1'b1, g);
        chk("post_reset_rr", 32'(g), 32'b0001);

        // Random traffic: a congested phase, then a mostly draining phase.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) != 0, 4'($urandom), $urandom,
                 (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0), g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
